// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock
// through a single full-subtractor cell with a registered borrow.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             bor_q, bor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic x, y, d_bit, bor_nxt;

  assign x       = sa_q[0];
  assign y       = sb_q[0];
  assign d_bit   = x ^ y ^ bor_q;
  assign bor_nxt = (~x & y) | (~(x ^ y) & bor_q);

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    bor_d   = bor_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          bor_d   = 1'b0;
          cnt_d   = CNT_LAST;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // result bits enter at the MSB; the oldest (bit 0) falls off the bottom
        sr_d  = WIDTH'({d_bit, sr_q} >> 1);
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        bor_d = bor_nxt;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          diff_d  = WIDTH'({d_bit, sr_q} >> 1);
          bout_d  = bor_nxt;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      bor_q   <= bor_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign busy       = (state_q == S_SHIFT);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor (WIDTH=8 and WIDTH=16)
// against an arithmetic reference: (a - b) mod 2^W and a < b.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  a, b, diff;
  logic        ready, busy, done, borrow_out;

  logic        start16;
  logic [15:0] a16, b16, diff16;
  logic        ready16, busy16, done16, borrow16;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .ready(ready16), .busy(busy16), .done(done16), .diff(diff16), .borrow_out(borrow16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_diff(input int unsigned w, input int unsigned x, input int unsigned y);
    longint unsigned m;
    m = longint'(1) << w;
    return 32'((longint'(x) + m - longint'(y)) % m);
  endfunction

  function automatic logic [31:0] ref_bor(input int unsigned x, input int unsigned y);
    return (x < y) ? 32'd1 : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full WIDTH=8 operation with latency and output checks.
  task automatic op8(input string tag, input logic [7:0] xa, input logic [7:0] xb);
    int n;
    n = 0;
    while (!ready && n < 20) begin tick(); n++; end
    chk({tag, "_ready"}, ready, 1);
    a = xa; b = xb; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_diff"}, diff, ref_diff(8, xa, xb));
    chk({tag, "_bor"}, borrow_out, ref_bor(xa, xb));
    tick();
    chk({tag, "_done1cyc"}, {done, ready}, 2'b01);
    chk({tag, "_hold"}, diff, ref_diff(8, xa, xb));
  endtask

  task automatic op16(input string tag, input logic [15:0] xa, input logic [15:0] xb);
    int n;
    n = 0;
    while (!ready16 && n < 40) begin tick(); n++; end
    a16 = xa; b16 = xb; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    a16 = $urandom; b16 = $urandom;
    n = 0;
    while (!done16 && n < 40) begin tick(); n++; end
    chk({tag, "_lat"}, n, 16);
    chk({tag, "_diff"}, diff16, ref_diff(16, xa, xb));
    chk({tag, "_bor"}, borrow16, ref_bor(xa, xb));
  endtask

  initial begin
    int rdy_cnt, done_cnt, first_done, last_done, bad_diff;
    logic [7:0] ra, rb;
    rst = 1'b1; start = 1'b1; a = 8'd9; b = 8'd3;
    start16 = 1'b0; a16 = '0; b16 = '0;
    tick(); tick();
    start = 1'b0;
    chk("rst_flags", {ready, busy, done}, 3'b100);
    chk("rst_diff", diff, 0);
    chk("rst_bor", borrow_out, 0);
    chk("rst16", {ready16, diff16, borrow16}, {1'b1, 16'd0, 1'b0});
    rst = 1'b0;
    tick();
    chk("rst_beats_start", {ready, busy}, 2'b10);

    op8("t1", 8'd200, 8'd55);
    op8("t2a", 8'd5, 8'd9);
    op8("t2b", 8'd0, 8'd1);
    op8("e00", 8'd0, 8'd0);
    op8("eFF", 8'd255, 8'd255);
    op8("eF0", 8'd255, 8'd0);
    op8("e0F", 8'd0, 8'd255);

    // start held high: accepts every 10 cycles
    a = 8'd100; b = 8'd1; start = 1'b1;
    rdy_cnt = 0; done_cnt = 0; first_done = -1; last_done = -1; bad_diff = 0;
    for (int c = 0; c < 30; c++) begin
      if (ready) rdy_cnt++;
      if (done) begin
        if (first_done < 0) first_done = c;
        last_done = c;
        done_cnt++;
        if (diff !== 8'd99 || borrow_out !== 1'b0) bad_diff++;
      end
      tick();
    end
    start = 1'b0;
    chk("t4_accepts", rdy_cnt, 3);
    chk("t4_dones", done_cnt, 3);
    chk("t4_first", first_done, 9);
    chk("t4_last", last_done, 29);
    chk("t4_result", bad_diff, 0);

    // operand changes and start pulses during SHIFT are ignored
    a = 8'd77; b = 8'd30; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'd1; b = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_busy", busy, 1);
    chk("t5_diff_held", diff, 99);
    begin
      int n;
      n = 0;
      while (!done && n < 20) begin tick(); n++; end
      chk("t5_lat", n, 5);
    end
    chk("t5_diff", diff, 47);
    chk("t5_bor", borrow_out, 0);
    tick();
    chk("t5_idle", ready, 1);

    // reset during the 4th SHIFT cycle
    a = 8'd50; b = 8'd20; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_flags", {ready, busy, done}, 3'b100);
    chk("t6_out", {diff, borrow_out}, 9'd0);
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) done_cnt++;
      tick();
    end
    chk("t6_nodone", done_cnt, 0);
    op8("t6_new", 8'd7, 8'd3);

    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      op8($sformatf("r8_%0d", i), ra, rb);
    end

    op16("w16_lo", 16'd0, 16'd1);
    op16("w16_hi", 16'hFFFF, 16'h0000);
    for (int i = 0; i < 25; i++)
      op16($sformatf("r16_%0d", i), 16'($urandom), 16'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
